// File: rtl/serv_rf_port_if.sv
// serv_rf_port_if: host-side request/response bundle for the regfile access port.
// Latency: none, wires only.
// Backpressure: the host holds i_req and its payload until o_ack.
interface serv_rf_port_if;
    logic        i_req;
    logic        i_we;
    logic [4:0]  i_addr;
    logic [31:0] i_wdata;
    logic        o_ack;
    logic [31:0] o_rdata;

    modport master (
        output i_req, i_we, i_addr, i_wdata,
        input  o_ack, o_rdata
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata,
        output o_ack, o_rdata
    );
endinterface

// File: rtl/serv_rf_port.sv
// serv_rf_port: word-parallel host access into the bit-serial regfile (initiator of rd/rs serial port).
// Latency: 33 cycles accept->o_ack (65 for writes with SERV_RF_PORT_VERIFY_EN), 1 cycle for a write to x0.
// Backpressure: host holds i_req until o_ack; acceptance waits while i_rf_busy is high in IDLE.
module serv_rf_port (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    serv_rf_port_if.slave        host,
    output logic                 o_busy,
    output logic                 o_err,
    input  logic                 i_rf_busy,
    output logic                 o_rf_rd_en,
    output logic [4:0]           o_rf_rd_addr,
    output logic                 o_rf_rd,
    output logic                 o_rf_rs_en,
    output logic [4:0]           o_rf_rs1_addr,
    input  logic                 i_rf_rs1
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
`ifdef SERV_RF_PORT_VERIFY_EN
    localparam logic [2:0] S_VERIFY = 3'd3;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [4:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        wr_phase;
    logic        rs_phase;
    logic        last_bit;

    assign accept   = (state_q == S_IDLE) && host.i_req && !i_rf_busy;
    assign wr_phase = (state_q == S_WRITE);
    assign last_bit = (cnt_q == 5'd31);
`ifdef SERV_RF_PORT_VERIFY_EN
    assign rs_phase = (state_q == S_READ) || (state_q == S_VERIFY);
`else
    assign rs_phase = (state_q == S_READ);
`endif

    // Next-state decode; every serial phase is exactly 32 enable cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!host.i_we)              state_d = S_READ;
                    else if (host.i_addr != 5'd0) state_d = S_WRITE;
                    else                         state_d = S_DONE;  // x0 is hardwired, skip the regfile
                end
            end
            S_WRITE: begin
`ifdef SERV_RF_PORT_VERIFY_EN
                if (last_bit) state_d = S_VERIFY;
`else
                if (last_bit) state_d = S_DONE;
`endif
            end
            S_READ: begin
                if (last_bit) state_d = S_DONE;
            end
`ifdef SERV_RF_PORT_VERIFY_EN
            S_VERIFY: begin
                if (last_bit) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, bit counter and latched request; counter wraps 31->0 at the end of each phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            addr_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= 5'd0;
                addr_q  <= host.i_addr;
                wdata_q <= host.i_wdata;
            end else if (wr_phase || rs_phase) begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    // Deserialise LSB-first: after 32 shifts bit 0 lands in rdata_q[0].
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdata_q <= 32'd0;
        end else if (rs_phase) begin
            rdata_q <= {i_rf_rs1, rdata_q[31:1]};
        end
    end

`ifdef SERV_RF_PORT_VERIFY_EN
    logic err_q;

    // Sticky readback mismatch flag, cleared by the next accepted request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if ((state_q == S_VERIFY) && (i_rf_rs1 != wdata_q[cnt_q])) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_busy        = (state_q != S_IDLE);
    assign host.o_ack    = (state_q == S_DONE);
    assign host.o_rdata  = rdata_q;
    assign o_rf_rd_en    = wr_phase;
    assign o_rf_rd       = wr_phase && wdata_q[cnt_q];
    assign o_rf_rd_addr  = wr_phase ? addr_q : 5'd0;
    assign o_rf_rs_en    = rs_phase;
    assign o_rf_rs1_addr = rs_phase ? addr_q : 5'd0;
endmodule
